// File: rtl/buyruk_onbellegi.sv
// Direct-mapped read-only instruction cache: combinational hit path, single-line refill on miss.
// Hit latency 0 cycles; a miss stalls fetch through ISTEK/DOLDUR until the last beat lands.
module buyruk_onbellegi #(
    parameter int SATIR_SAYISI = 64,
    parameter int SATIR_KELIME = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] getir_ps_i,
    input  logic        getir_temizle_i,
    output logic        getir_gecerli_o,
    output logic [31:0] getir_buyruk_o,
    output logic        getir_bekle_o,
    output logic        bellek_istek_o,
    output logic [31:0] bellek_adres_o,
    input  logic        bellek_hazir_i,
    input  logic        bellek_veri_gecerli_i,
    input  logic [31:0] bellek_veri_i
);
    localparam int OW = $clog2(SATIR_KELIME);
    localparam int IW = $clog2(SATIR_SAYISI);
    localparam int TW = 30 - OW - IW;

    typedef enum logic [1:0] {BOS, ISTEK, DOLDUR} durum_t;
    durum_t durum;

    logic [31:0]             veri      [SATIR_SAYISI*SATIR_KELIME];
    logic [TW-1:0]           etiketler [SATIR_SAYISI];
    logic [SATIR_SAYISI-1:0] gecerli;

    logic [OW-1:0] ofs;
    logic [IW-1:0] idx;
    logic [TW-1:0] etiket;
    logic [TW+IW-1:0] hat_adres;
    logic [IW-1:0] hat_idx;
    logic [TW-1:0] hat_etiket;
    logic [OW-1:0] sayac;
    logic          temizle_bekliyor;
    logic          istek;
    logic          isabet;
    logic          son_beat;

    assign ofs        = getir_ps_i[2 +: OW];
    assign idx        = getir_ps_i[2+OW +: IW];
    assign etiket     = getir_ps_i[31 -: TW];
    assign hat_idx    = hat_adres[IW-1:0];
    assign hat_etiket = hat_adres[IW +: TW];

    assign isabet   = (durum == BOS) && gecerli[idx] && (etiketler[idx] == etiket);
    assign son_beat = (durum == DOLDUR) && bellek_veri_gecerli_i &&
                      (sayac == OW'(SATIR_KELIME - 1));

    assign getir_gecerli_o = isabet;
    assign getir_buyruk_o  = veri[{idx, ofs}];
    assign getir_bekle_o   = !isabet;
    assign bellek_istek_o  = istek;
    assign bellek_adres_o  = istek ? {hat_adres, {(OW+2){1'b0}}} : 32'h0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum            <= BOS;
            gecerli          <= '0;
            istek            <= 1'b0;
            sayac            <= '0;
            temizle_bekliyor <= 1'b0;
        end else begin
            case (durum)
                BOS: begin
                    if (!isabet) begin
                        hat_adres <= getir_ps_i[31:2+OW];
                        istek     <= 1'b1;
                        durum     <= ISTEK;
                    end
                end
                ISTEK: begin
                    if (bellek_hazir_i) begin
                        istek <= 1'b0;
                        sayac <= '0;
                        durum <= DOLDUR;
                    end
                end
                DOLDUR: begin
                    if (bellek_veri_gecerli_i) begin
                        sayac <= sayac + 1'b1;
                    end
                    if (son_beat) begin
                        durum            <= BOS;
                        temizle_bekliyor <= 1'b0;
                        if (!(temizle_bekliyor || getir_temizle_i)) begin
                            gecerli[hat_idx] <= 1'b1;
                        end
                    end
                end
                default: durum <= BOS;
            endcase
            // A flush mid-refill must keep the incoming line invalid when it completes.
            if (getir_temizle_i) begin
                gecerli <= '0;
                if (durum != BOS && !son_beat) begin
                    temizle_bekliyor <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && durum == DOLDUR && bellek_veri_gecerli_i) begin
            veri[{hat_idx, sayac}] <= bellek_veri_i;
            if (son_beat) begin
                etiketler[hat_idx] <= hat_etiket;
            end
        end
    end
endmodule
